// File: rtl/aes_sched_pkg.sv
// Shared definitions for the AES request scheduler: FSM encoding, default widths,
// and the watchdog counter sizing helper.
package aes_sched_pkg;

  localparam int DEF_AES_LEN    = 128;
  localparam int DEF_ADDR_WIDTH = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Counter only has to reach TIMEOUT_CYC-1 before the FSM leaves WAIT.
  function automatic int wd_width(input int timeout_cyc);
    return (timeout_cyc > 2) ? $clog2(timeout_cyc) : 1;
  endfunction

endpackage

// File: rtl/aes_req_scheduler_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N, returned as one-hot, index and an any-request flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest slot back to ptr so the nearest hit is written last.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    grant[idx] = any;
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one AES-128 engine between NUM_REQ requesters: round-robin grant,
// single job in flight, registered per-requester response, done watchdog.
module aes_req_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int AES_LEN     = DEF_AES_LEN,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_key_addr,
  input  logic [NUM_REQ*AES_LEN-1:0]    req_plaintext,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [AES_LEN-1:0]            rsp_result,
  output logic                          rsp_err,
  output logic                          aes_start,
  output logic [ADDR_WIDTH-1:0]         aes_key_addr,
  output logic [AES_LEN-1:0]            aes_plaintext,
  input  logic [AES_LEN-1:0]            aes_result,
  input  logic                          aes_done,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int CNT_W = wd_width(TIMEOUT_CYC);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [1:0]         state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic               pick_any;
  logic [CNT_W-1:0]   cnt;
  logic               timeout;

  rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is offered only while idle, so no grant survives into a busy state.
  assign req_ready = (state == ST_IDLE) ? pick_oh : '0;
  assign aes_start = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign timeout   = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      cnt           <= '0;
      aes_key_addr  <= '0;
      aes_plaintext <= '0;
      rsp_valid     <= '0;
      rsp_result    <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            aes_key_addr  <= req_key_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
            aes_plaintext <= req_plaintext[pick_idx*AES_LEN +: AES_LEN];
            grant_id      <= pick_idx;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt <= cnt + 1'b1;
          // A done arriving in the final watchdog cycle still counts as success.
          if (aes_done) begin
            rsp_result <= aes_result;
            rsp_err    <= 1'b0;
            rsp_valid  <= ONE << grant_id;
            state      <= ST_RESP;
          end else if (timeout) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= ONE << grant_id;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rr_ptr    <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_req_scheduler.sv
// Directed bench for aes_req_scheduler: table of single jobs with a behavioural
// engine, plus hand sequences for reset-in-flight and late done.
module tb_aes_req_scheduler;

  localparam int NR = 4;
  localparam int AL = 128;
  localparam int AW = 5;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_key_addr = '0;
  logic [NR*AL-1:0]  req_plaintext = '0;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready = '0;
  logic [AL-1:0]     rsp_result;
  logic              rsp_err;
  logic              aes_start;
  logic [AW-1:0]     aes_key_addr;
  logic [AL-1:0]     aes_plaintext;
  logic [AL-1:0]     aes_result = '0;
  logic              aes_done = 1'b0;
  logic              busy;
  logic [1:0]        grant_id;

  aes_req_scheduler #(.NUM_REQ(NR), .AES_LEN(AL), .ADDR_WIDTH(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key_addr(req_key_addr), .req_plaintext(req_plaintext),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .aes_start(aes_start), .aes_key_addr(aes_key_addr), .aes_plaintext(aes_plaintext),
    .aes_result(aes_result), .aes_done(aes_done),
    .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    int         gid;
    int         lat;
    int         exp_n;
    logic       exp_err;
    int         hold;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0] key [NR];
  logic [AL-1:0] pt  [NR];
  vec_t tbl [11];

  task automatic chk(input string name, input logic [AL-1:0] act, input logic [AL-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [AL-1:0] res_of(input int g);
    return {pt[g][63:0], pt[g][127:64]} ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
  endfunction

  task automatic run_job(input vec_t v);
    logic [3:0] oh;
    int n;
    @(negedge clk);
    req_valid = v.valid;
    rsp_ready = '0;
    #1;
    chk("req_ready", 128'(req_ready), 128'(v.exp_ready));
    if (v.gid < 0) begin
      aes_done   = 1'b1;
      aes_result = '1;
      @(posedge clk); #1;
      aes_done = 1'b0;
      chk("idle_busy", 128'(busy), 128'd0);
      chk("idle_rsp_valid", 128'(rsp_valid), 128'd0);
      chk("idle_start", 128'(aes_start), 128'd0);
      return;
    end
    oh = 4'b0001 << v.gid;
    @(posedge clk); #1;
    chk("issue_start", 128'(aes_start), 128'd1);
    chk("issue_busy", 128'(busy), 128'd1);
    chk("grant_id", 128'(grant_id), 128'(v.gid));
    chk("aes_key_addr", 128'(aes_key_addr), 128'(key[v.gid]));
    chk("aes_plaintext", aes_plaintext, pt[v.gid]);
    chk("busy_req_ready", 128'(req_ready), 128'd0);
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      aes_done = 1'b0;
      if (n == 1) chk("start_pulse", 128'(aes_start), 128'd0);
      if (rsp_valid != '0 || n > 40) break;
      if (n == v.lat) begin
        aes_done   = 1'b1;
        aes_result = res_of(v.gid);
      end
    end
    chk("rsp_cycle", 128'(n), 128'(v.exp_n));
    chk("rsp_valid", 128'(rsp_valid), 128'(oh));
    chk("rsp_err", 128'(rsp_err), 128'(v.exp_err));
    chk("rsp_result", rsp_result, v.exp_err ? '0 : res_of(v.gid));
    chk("key_stable", 128'(aes_key_addr), 128'(key[v.gid]));
    rsp_ready = ~oh;
    repeat (v.hold) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", 128'(rsp_valid), 128'(oh));
      chk("hold_rsp_result", rsp_result, v.exp_err ? '0 : res_of(v.gid));
      chk("hold_req_ready", 128'(req_ready), 128'd0);
      chk("hold_start", 128'(aes_start), 128'd0);
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = '0;
    chk("rel_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rel_rsp_err", 128'(rsp_err), 128'd0);
    chk("rel_busy", 128'(busy), 128'd0);
  endtask

  initial begin
    key[0] = 5'd9;  key[1] = 5'd17; key[2] = 5'd3; key[3] = 5'd30;
    pt[0] = 128'hfedcba98_76543210_01234567_89abcdef;
    pt[1] = 128'h0badf00d_deadbeef_cafebabe_13572468;
    pt[2] = 128'h00112233_44556677_8899aabb_ccddeeff;
    pt[3] = 128'h11111111_22222222_33333333_44444444;
    for (int i = 0; i < NR; i++) begin
      req_key_addr[i*AW +: AW]  = key[i];
      req_plaintext[i*AL +: AL] = pt[i];
    end
    //           valid    ready    gid lat n  err   hold
    tbl[0]  = '{4'b0100, 4'b0100,  2,  6, 7, 1'b0,  3};
    tbl[1]  = '{4'b1111, 4'b1000,  3,  1, 2, 1'b0,  0};
    tbl[2]  = '{4'b1111, 4'b0001,  0,  2, 3, 1'b0,  0};
    tbl[3]  = '{4'b1111, 4'b0010,  1,  3, 4, 1'b0,  1};
    tbl[4]  = '{4'b1111, 4'b0100,  2,  4, 5, 1'b0,  0};
    tbl[5]  = '{4'b1111, 4'b1000,  3,  5, 6, 1'b0,  0};
    tbl[6]  = '{4'b1111, 4'b0001,  0,  0, 9, 1'b1, 10};
    tbl[7]  = '{4'b0000, 4'b0000, -1,  0, 0, 1'b0,  0};
    tbl[8]  = '{4'b0010, 4'b0010,  1,  8, 9, 1'b0,  0};
    tbl[9]  = '{4'b0011, 4'b0001,  0,  1, 2, 1'b0,  0};
    tbl[10] = '{4'b0110, 4'b0010,  1,  7, 8, 1'b0,  2};

    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("rst_req_ready", 128'(req_ready), 128'd0);
    chk("rst_start", 128'(aes_start), 128'd0);
    chk("rst_grant_id", 128'(grant_id), 128'd0);
    chk("rst_rsp_err", 128'(rsp_err), 128'd0);
    chk("rst_key", 128'(aes_key_addr), 128'd0);
    chk("rst_result", rsp_result, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_job(tbl[i]);
      if (i == 5) chk("rr_ptr_wrap", 128'(dut.rr_ptr), 128'd0);
    end

    // Reset while the engine is busy: job dropped, pointer back to 0.
    @(negedge clk);
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("mid_rst_rr_ptr", 128'(dut.rr_ptr), 128'd0);
    chk("mid_rst_grant_id", 128'(grant_id), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_job('{4'b1000, 4'b1000, 3, 2, 3, 1'b0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end

endmodule
